// File: rtl/seq_hit_logger.sv
// Timestamps sequence-detector hits into a show-ahead FIFO with a saturating hit counter.
// Optional registered fill-level interrupt is enabled by defining SEQ_LOG_IRQ_EN.
module seq_hit_logger #(
    parameter int unsigned POS_W      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned IRQ_THRESH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_clr,
    input  logic                     i_hit,
    output logic                     o_rd_valid,
    output logic [POS_W-1:0]         o_rd_data,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [CNT_W-1:0]         o_hit_count,
`ifdef SEQ_LOG_IRQ_EN
    output logic                     o_overflow,
    output logic                     o_irq
`else
    output logic                     o_overflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [POS_W-1:0] r_mem [DEPTH];
    logic [POS_W-1:0] r_pos;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_overflow;

    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [LW-1:0]    w_level_d;

    always_comb begin
        w_pop     = (r_level != '0) & i_rd_ready;
        w_full    = (r_level == FULL_LVL);
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        w_push    = i_hit & (~w_full | w_pop);
        w_level_d = r_level;
        if (w_push && !w_pop) begin
            w_level_d = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_d = r_level - LW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_pos       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_pos       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_pos <= r_pos + POS_W'(1);
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_pos;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_d;
            if (i_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end
            if (i_hit && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SEQ_LOG_IRQ_EN
    logic r_irq;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_irq <= 1'b0;
        end else if (i_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_level >= LW'(IRQ_THRESH)) | r_overflow;
        end
    end

    assign o_irq = r_irq;
`endif

    assign o_rd_valid  = (r_level != '0);
    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign o_hit_count = r_hit_count;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_seq_hit_logger.sv
// Randomized and directed bench for seq_hit_logger: a wide instance and a narrow (wrap/saturate)
// instance share stimulus and are compared against a queue-based reference model.
module tb_seq_hit_logger;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned THRESH = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        hit;
    logic        rdy;

    logic        valid_a, valid_b;
    logic [15:0] data_a;
    logic [3:0]  data_b;
    logic [3:0]  level_a, level_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic        ovf_a, ovf_b;
`ifdef SEQ_LOG_IRQ_EN
    logic        irq_a, irq_b;
`endif

    seq_hit_logger #(.POS_W(16), .DEPTH(DEPTH), .CNT_W(8), .IRQ_THRESH(THRESH)) dut_a (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_clr       (clr),
        .i_hit       (hit),
        .o_rd_valid  (valid_a),
        .o_rd_data   (data_a),
        .i_rd_ready  (rdy),
        .o_level     (level_a),
        .o_hit_count (cnt_a),
`ifdef SEQ_LOG_IRQ_EN
        .o_overflow  (ovf_a),
        .o_irq       (irq_a)
`else
        .o_overflow  (ovf_a)
`endif
    );

    seq_hit_logger #(.POS_W(4), .DEPTH(DEPTH), .CNT_W(2), .IRQ_THRESH(THRESH)) dut_b (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_clr       (clr),
        .i_hit       (hit),
        .o_rd_valid  (valid_b),
        .o_rd_data   (data_b),
        .i_rd_ready  (rdy),
        .o_level     (level_b),
        .o_hit_count (cnt_b),
`ifdef SEQ_LOG_IRQ_EN
        .o_overflow  (ovf_b),
        .o_irq       (irq_b)
`else
        .o_overflow  (ovf_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: unbounded position, stamps in a queue, masked per instance on compare.
    int m_pos;
    int m_q[$];
    int m_cnt;
    bit m_ovf;
    bit m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_q.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_irq = 0;
    endtask

    task automatic model_edge(input bit h, input bit r, input bit c);
        bit irq_n;
        if (c) begin
            model_reset();
            return;
        end
        irq_n = (m_q.size() >= int'(THRESH)) || m_ovf;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (h) begin
            m_cnt++;
            if (m_q.size() < int'(DEPTH)) m_q.push_back(m_pos);
            else m_ovf = 1;
        end
        m_pos++;
        m_irq = irq_n;
    endtask

    task automatic check_all();
        int sat_a;
        int sat_b;
        sat_a = (m_cnt > 255) ? 255 : m_cnt;
        sat_b = (m_cnt > 3) ? 3 : m_cnt;
        check("valid_a", 32'(valid_a), 32'(m_q.size() > 0));
        check("valid_b", 32'(valid_b), 32'(m_q.size() > 0));
        check("level_a", 32'(level_a), 32'(m_q.size()));
        check("level_b", 32'(level_b), 32'(m_q.size()));
        if (m_q.size() > 0) begin
            check("data_a", 32'(data_a), 32'(m_q[0] % 65536));
            check("data_b", 32'(data_b), 32'(m_q[0] % 16));
        end
        check("cnt_a", 32'(cnt_a), 32'(sat_a));
        check("cnt_b", 32'(cnt_b), 32'(sat_b));
        check("ovf_a", 32'(ovf_a), 32'(m_ovf));
        check("ovf_b", 32'(ovf_b), 32'(m_ovf));
`ifdef SEQ_LOG_IRQ_EN
        check("irq_a", 32'(irq_a), 32'(m_irq));
        check("irq_b", 32'(irq_b), 32'(m_irq));
`endif
    endtask

    // Inputs change just after a falling edge; outputs are checked on the next falling edge.
    task automatic step(input bit h, input bit r, input bit c);
        hit = h;
        rdy = r;
        clr = c;
        @(posedge clk);
        model_edge(h, r, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'({valid_a, valid_b}), 32'd0);
        check({tag, "_data"},  32'({data_a, data_b}), 32'd0);
        check({tag, "_level"}, 32'({level_a, level_b}), 32'd0);
        check({tag, "_cnt"},   32'({cnt_a, cnt_b}), 32'd0);
        check({tag, "_ovf"},   32'({ovf_a, ovf_b}), 32'd0);
`ifdef SEQ_LOG_IRQ_EN
        check({tag, "_irq"},   32'({irq_a, irq_b}), 32'd0);
`endif
    endtask

    initial begin
        int p_hit;
        int p_rdy;
        hit   = 1'b0;
        rdy   = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // Single hit stamped with pos=5.
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        check("t2_data", 32'(data_a), 32'd5);
        check("t2_level", 32'(level_a), 32'd1);
        check("t2_cnt", 32'(cnt_a), 32'd1);

        // Async reset mid-operation with level=3, asserted away from any clock edge.
        step(1, 0, 0);
        step(1, 0, 0);
        check("t1_level", 32'(level_a), 32'd3);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        check("t1_restart", 32'(data_a), 32'd0);

        // Fill past full, then drain in order.
        step(0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0);
        check("t3_level", 32'(level_a), 32'd8);
        check("t3_ovf", 32'(ovf_a), 32'd1);
        check("t3_cnt", 32'(cnt_a), 32'd9);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        check("t3_empty", 32'(valid_a), 32'd0);

        // Full with simultaneous push and pop.
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 1, 0);
        check("t4_level", 32'(level_a), 32'd8);
        check("t4_ovf", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);

        // Narrow instance: stamps 15 then 0, counter saturates at 3.
        step(0, 0, 1);
        repeat (15) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("t5_head", 32'(data_b), 32'd15);
        step(0, 1, 0);
        check("t5_wrap", 32'(data_b), 32'd0);
        repeat (4) step(1, 0, 0);
        check("t5_sat", 32'(cnt_b), 32'd3);

        // clr wins over hit and rd_ready.
        step(1, 1, 1);
        check("t6_level", 32'(level_a), 32'd0);
        check("t6_cnt", 32'(cnt_a), 32'd0);

        // Randomized phases with varying hit/ready densities.
        for (int ph = 0; ph < 8; ph++) begin
            p_hit = $urandom_range(10, 90);
            p_rdy = $urandom_range(10, 90);
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(0, 99) < p_hit), ($urandom_range(0, 99) < p_rdy),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
